fetch_stage: RTL and testbench

//  IF stage of the 5-stage RV32I pipeline: PC register, sync instruction-memory request, 1-entry hold buffer, IF/ID register.

---
 rtl/rv32_pkg.sv | 35 +++
 rtl/fetch_hold_buffer.sv | 29 ++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline constants: datapath width, reset/bubble values,
// base opcodes used by the decoder and hazard logic, and the IF action encoding.
package rv32_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    IF_ADVANCE = 2'd0,
    IF_STALL   = 2'd1,
    IF_FLUSH   = 2'd2,
    IF_RESET   = 2'd3
  } if_action_e;

  // Reset beats redirect, redirect beats stall.
  function automatic if_action_e if_action(input logic rst, input logic flush,
                                           input logic advance);
    if (rst)          return IF_RESET;
    else if (flush)   return IF_FLUSH;
    else if (!advance) return IF_STALL;
    else              return IF_ADVANCE;
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry parking slot for an instruction that returns from memory while IF is stalled.
module fetch_hold_buffer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic            consume,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC register, 1-cycle-latency imem request, stall hold buffer and IF/ID register.
module fetch_stage #(
  parameter int                 XLEN      = rv32_pkg::XLEN,
  parameter logic [XLEN-1:0]    RESET_PC  = rv32_pkg::RESET_PC,
  parameter logic [31:0]        NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            IF_pcWriteEnable,
  input  logic            IF_flush,
  input  logic [XLEN-1:0] EX_branchTarget,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] ID_pc,
  output logic [XLEN-1:0] ID_pcPlus4,
  output logic [31:0]     ID_instr,
  output logic            ID_valid,
  output logic            IF_misalignedTarget
);
  import rv32_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  if_action_e      action;
  logic [XLEN-1:0] pc_q;
  logic            inflight_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic [XLEN-1:0] tgt;

  logic            hold_valid;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_instr;
  logic            hold_load;
  logic            hold_clear;
  logic            hold_consume;

  logic            id_load;
  logic            id_next_valid;
  logic [XLEN-1:0] id_next_pc;
  logic [31:0]     id_next_instr;

  always_comb begin
    action    = if_action(rst, IF_flush, IF_pcWriteEnable);
    tgt       = {EX_branchTarget[XLEN-1:2], 2'b00};
    imem_req  = !rst && (IF_flush || IF_pcWriteEnable);
    imem_addr = IF_flush ? tgt : pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (imem_req) begin
      pc_q          <= imem_addr + PC_STEP;
      inflight_q    <= 1'b1;
      inflight_pc_q <= imem_addr;
    end else begin
      inflight_q    <= 1'b0;
    end
  end

  always_comb begin
    hold_load    = (action == IF_STALL) && inflight_q;
    hold_clear   = (action == IF_FLUSH);
    hold_consume = (action == IF_ADVANCE) && hold_valid;
  end

  fetch_hold_buffer #(.XLEN(XLEN)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .clear    (hold_clear),
    .consume  (hold_consume),
    .pc_in    (inflight_pc_q),
    .instr_in (imem_rdata),
    .valid    (hold_valid),
    .pc       (hold_pc),
    .instr    (hold_instr)
  );

  // A parked instruction is older than any response, so it is drained first.
  always_comb begin
    id_load       = 1'b0;
    id_next_valid = 1'b0;
    id_next_pc    = inflight_pc_q;
    id_next_instr = imem_rdata;
    case (action)
      IF_ADVANCE: begin
        id_load = 1'b1;
        if (hold_valid) begin
          id_next_valid = 1'b1;
          id_next_pc    = hold_pc;
          id_next_instr = hold_instr;
        end else if (inflight_q) begin
          id_next_valid = 1'b1;
        end
      end
      IF_FLUSH: id_load = 1'b1;
      default:  id_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ID_valid            <= 1'b0;
      ID_instr            <= NOP_INSTR;
      ID_pc               <= '0;
      ID_pcPlus4          <= '0;
      IF_misalignedTarget <= 1'b0;
    end else begin
      IF_misalignedTarget <= IF_flush && (|EX_branchTarget[1:0]);
      if (id_load) begin
        ID_valid <= id_next_valid;
        ID_instr <= id_next_valid ? id_next_instr : NOP_INSTR;
        if (id_next_valid) begin
          ID_pc      <= id_next_pc;
          ID_pcPlus4 <= id_next_pc + PC_STEP;
        end
      end
    end
  end

  // No request is issued while stalled, so a parked entry and a pending response never coexist.
  hold_exclusive: assert property (@(posedge clk) disable iff (rst) !(hold_valid && inflight_q));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model with 1-cycle latency and an expected-ID queue.
module tb_fetch_stage;

  localparam int          W_EXP = 35;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        IF_pcWriteEnable;
  logic        IF_flush;
  logic [31:0] EX_branchTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ID_pc;
  logic [31:0] ID_pcPlus4;
  logic [31:0] ID_instr;
  logic        ID_valid;
  logic        IF_misalignedTarget;

  int n_checks = 0;
  int n_errors = 0;
  int step_no  = 0;

  // {check_pc, valid, misaligned, pc}
  logic [W_EXP-1:0] exp_q[$];

  fetch_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .IF_pcWriteEnable    (IF_pcWriteEnable),
    .IF_flush            (IF_flush),
    .EX_branchTarget     (EX_branchTarget),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_rdata          (imem_rdata),
    .ID_pc               (ID_pc),
    .ID_pcPlus4          (ID_pcPlus4),
    .ID_instr            (ID_instr),
    .ID_valid            (ID_valid),
    .IF_misalignedTarget (IF_misalignedTarget)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[17:2]};
  endfunction

  // Instruction memory: answer the request one edge later, garbage otherwise.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
    else          imem_rdata <= $urandom;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, check the request, then score ID after the edge.
  task automatic step(input logic r, input logic we, input logic fl, input logic [31:0] tgt,
                      input logic ereq, input logic [31:0] eaddr,
                      input logic evalid, input logic chk_pc, input logic [31:0] epc,
                      input logic emis);
    logic [W_EXP-1:0] e;
    logic [31:0]      pc_e;
    step_no++;
    rst              = r;
    IF_pcWriteEnable = we;
    IF_flush         = fl;
    EX_branchTarget  = tgt;
    exp_q.push_back({chk_pc, evalid, emis, epc});
    #1;
    check("imem_req", {31'd0, imem_req}, {31'd0, ereq});
    if (ereq) check("imem_addr", imem_addr, eaddr);
    @(posedge clk);
    #1;
    e    = exp_q.pop_front();
    pc_e = e[31:0];
    check("ID_valid", {31'd0, ID_valid}, {31'd0, e[33]});
    check("ID_instr", ID_instr, e[33] ? mem_word(pc_e) : NOP);
    check("IF_misalignedTarget", {31'd0, IF_misalignedTarget}, {31'd0, e[32]});
    if (e[34]) begin
      check("ID_pc", ID_pc, pc_e);
      check("ID_pcPlus4", ID_pcPlus4, e[33] ? pc_e + 32'd4 : 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; IF_pcWriteEnable = 1'b1; IF_flush = 1'b0; EX_branchTarget = '0;
    imem_rdata = '0;

    // Reset values
    step(1, 1, 0, 0,            0, 0,            0, 1, 0,            0);
    step(1, 1, 0, 0,            0, 0,            0, 1, 0,            0);
    // T1: streaming from RESET_PC
    step(0, 1, 0, 0,            1, 32'h0,        0, 0, 0,            0);
    step(0, 1, 0, 0,            1, 32'h4,        1, 1, 32'h0,        0);
    step(0, 1, 0, 0,            1, 32'h8,        1, 1, 32'h4,        0);
    step(0, 1, 0, 0,            1, 32'hC,        1, 1, 32'h8,        0);
    // T2: one stall cycle with pc 8 in ID
    step(0, 0, 0, 0,            0, 0,            1, 1, 32'h8,        0);
    step(0, 1, 0, 0,            1, 32'h10,       1, 1, 32'hC,        0);
    step(0, 1, 0, 0,            1, 32'h14,       1, 1, 32'h10,       0);
    step(0, 1, 0, 0,            1, 32'h18,       1, 1, 32'h14,       0);
    step(0, 1, 0, 0,            1, 32'h1C,       1, 1, 32'h18,       0);
    step(0, 1, 0, 0,            1, 32'h20,       1, 1, 32'h1C,       0);
    step(0, 1, 0, 0,            1, 32'h24,       1, 1, 32'h20,       0);
    // T3: flush to 0x100
    step(0, 1, 1, 32'h100,      1, 32'h100,      0, 0, 0,            0);
    step(0, 1, 0, 0,            1, 32'h104,      1, 1, 32'h100,      0);
    step(0, 1, 0, 0,            1, 32'h108,      1, 1, 32'h104,      0);
    // T4: fill hold, then flush+stall to 0x200
    step(0, 0, 0, 0,            0, 0,            1, 1, 32'h104,      0);
    step(0, 0, 1, 32'h200,      1, 32'h200,      0, 0, 0,            0);
    step(0, 1, 0, 0,            1, 32'h204,      1, 1, 32'h200,      0);
    step(0, 1, 0, 0,            1, 32'h208,      1, 1, 32'h204,      0);
    // T5: misaligned flush target
    step(0, 1, 1, 32'h102,      1, 32'h100,      0, 0, 0,            1);
    step(0, 1, 0, 0,            1, 32'h104,      1, 1, 32'h100,      0);
    step(0, 1, 0, 0,            1, 32'h108,      1, 1, 32'h104,      0);
    // T6: reset with hold full
    step(0, 0, 0, 0,            0, 0,            1, 1, 32'h104,      0);
    step(1, 1, 0, 0,            0, 0,            0, 1, 0,            0);
    step(0, 1, 0, 0,            1, 32'h0,        0, 0, 0,            0);
    step(0, 1, 0, 0,            1, 32'h4,        1, 1, 32'h0,        0);
    step(0, 1, 0, 0,            1, 32'h8,        1, 1, 32'h4,        0);
    step(0, 1, 0, 0,            1, 32'hC,        1, 1, 32'h8,        0);
    // Reset with a response in flight: the stale word must be dropped
    step(1, 1, 0, 0,            0, 0,            0, 1, 0,            0);
    step(0, 1, 0, 0,            1, 32'h0,        0, 0, 0,            0);
    step(0, 1, 0, 0,            1, 32'h4,        1, 1, 32'h0,        0);
    // PC wrap at the top of the address space
    step(0, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 0,          0);
    step(0, 1, 0, 0,            1, 32'h0,        1, 1, 32'hFFFF_FFFC, 0);
    step(0, 1, 0, 0,            1, 32'h4,        1, 1, 32'h0,        0);

    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
